alarm_time_ctrl: RTL and testbench

Parametrised successor of the asynchronous alarm-setting counters. Fully synchronous to one clock. Holds the alarm minute/hour set-points with edge-detected, auto-repeating advance buttons and programmable moduli. Adds an alarm engine that compares set-points against the live time-of-day, rings, snoozes and times out. Sits between the button synchroniser and the display/buzzer driver.

---
 rtl/alarm_time_ctrl_pkg.sv | 29 ++
 rtl/alarm_time_ctrl_if.sv | 31 +++
 rtl/alarm_time_ctrl_adv_ctr.sv | 84 ++++++++
 rtl/alarm_time_ctrl.sv | 147 ++++++++++++++
 tb/tb_alarm_time_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_time_ctrl_pkg.sv
// alarm_pkg: shared types and width helpers for the alarm set-point/ring controller.
//   alarm_state_e : alarm engine states
//   rep_cnt_w()   : auto-repeat hold counter width from max(REP_DLY, REP_PER)
//   min_cnt_w()   : snooze/ring minute counter width from max(SNOOZE_MIN, RING_MIN)
package alarm_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Enough bits to hold the larger of the two repeat thresholds.
    function automatic int unsigned rep_cnt_w(input int unsigned dly, input int unsigned per);
        return $clog2(max_u(dly, per) + 1);
    endfunction

    // Enough bits to hold the larger of the two minute reload values.
    function automatic int unsigned min_cnt_w(input int unsigned snz, input int unsigned ring);
        return $clog2(max_u(snz, ring) + 1);
    endfunction

endpackage

// File: rtl/alarm_time_ctrl_if.sv
// alarm_time_ctrl_if: button/time inputs and set-point/buzzer outputs of alarm_time_ctrl.
//   master : button synchroniser / time-of-day side (drives inputs, reads outputs)
//   slave  : alarm_time_ctrl side
interface alarm_time_ctrl_if #(
    parameter int unsigned MIN_W = 6,
    parameter int unsigned HR_W  = 5
);
    logic             SETUP;
    logic             MIN_ADV;
    logic             HR_ADV;
    logic             ALARM_EN;
    logic             SNOOZE;
    logic             MIN_TICK;
    logic [MIN_W-1:0] TIME_MIN;
    logic [HR_W-1:0]  TIME_HR;
    logic [MIN_W-1:0] MINUTES;
    logic [HR_W-1:0]  HOURS;
    logic             RING;
    logic             SNOOZING;

    modport master (
        output SETUP, MIN_ADV, HR_ADV, ALARM_EN, SNOOZE, MIN_TICK, TIME_MIN, TIME_HR,
        input  MINUTES, HOURS, RING, SNOOZING
    );

    modport slave (
        input  SETUP, MIN_ADV, HR_ADV, ALARM_EN, SNOOZE, MIN_TICK, TIME_MIN, TIME_HR,
        output MINUTES, HOURS, RING, SNOOZING
    );

endinterface

// File: rtl/alarm_time_ctrl_adv_ctr.sv
// alarm_adv_ctr: one set-point channel. Rising-edge advance, auto-repeat while held,
// modulo-MOD wrap.
//   C, CLR_N : clock, async active-low reset
//   EN       : advance enable (set mode)
//   BTN      : advance button level
//   VAL      : registered set-point value
module alarm_adv_ctr
    import alarm_pkg::*;
#(
    parameter int unsigned W       = 6,
    parameter int unsigned MOD     = 60,
    parameter int unsigned REP_DLY = 500,
    parameter int unsigned REP_PER = 100
) (
    input  logic         C,
    input  logic         CLR_N,
    input  logic         EN,
    input  logic         BTN,
    output logic [W-1:0] VAL
);

    localparam int unsigned RW = rep_cnt_w(REP_DLY, REP_PER);

    if (64'(MOD) > (64'(1) << W)) begin : g_bad_mod
        $error("alarm_adv_ctr: MOD exceeds 2**W");
    end
    if (MOD < 1 || REP_DLY < 1 || REP_PER < 1) begin : g_bad_rep
        $error("alarm_adv_ctr: MOD, REP_DLY and REP_PER must be >= 1");
    end

    logic          btn_q, btn_d;
    logic          edge_q, edge_d;
    logic          armed_q, armed_d;
    logic          phase_q, phase_d;
    logic [RW-1:0] hold_q, hold_d;
    logic [W-1:0]  val_q, val_d;

    logic rise_c, held_c, fire_c, inc_c;

    // Edge detect, hold counting and value update. armed_q is only set by a fresh
    // rising edge in set mode, so a button already down when set mode begins never repeats.
    // phase_q selects the initial REP_DLY wait versus the REP_PER repeat period.
    always_comb begin
        btn_d   = BTN;
        rise_c  = EN & BTN & ~btn_q;
        held_c  = EN & BTN & (armed_q | rise_c);
        fire_c  = EN & BTN & armed_q &
                  (phase_q ? (hold_q == RW'(REP_PER)) : (hold_q == RW'(REP_DLY)));
        edge_d  = rise_c;
        armed_d = held_c;
        phase_d = held_c & (phase_q | fire_c);
        hold_d  = '0;
        if (held_c) begin
            hold_d = fire_c ? RW'(1) : (hold_q + RW'(1));
        end
        inc_c = EN & (edge_q | fire_c);
        val_d = val_q;
        if (inc_c) begin
            val_d = (val_q == W'(MOD - 1)) ? '0 : (val_q + W'(1));
        end
    end

    // Channel state registers.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            btn_q   <= 1'b0;
            edge_q  <= 1'b0;
            armed_q <= 1'b0;
            phase_q <= 1'b0;
            hold_q  <= '0;
            val_q   <= '0;
        end else begin
            btn_q   <= btn_d;
            edge_q  <= edge_d;
            armed_q <= armed_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            val_q   <= val_d;
        end
    end

    assign VAL = val_q;

endmodule

// File: rtl/alarm_time_ctrl.sv
// alarm_time_ctrl: alarm minute/hour set-points plus ring/snooze/timeout engine.
//   C, CLR_N : clock, async active-low reset
//   bus      : slave side of alarm_time_ctrl_if (buttons, time-of-day in;
//              MINUTES/HOURS set-points, RING, SNOOZING out, all registered)
module alarm_time_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned MIN_W      = 6,
    parameter int unsigned HR_W       = 5,
    parameter int unsigned MIN_MOD    = 60,
    parameter int unsigned HR_MOD     = 24,
    parameter int unsigned REP_DLY    = 500,
    parameter int unsigned REP_PER    = 100,
    parameter int unsigned SNOOZE_MIN = 9,
    parameter int unsigned RING_MIN   = 5
) (
    input  logic              C,
    input  logic              CLR_N,
    alarm_time_ctrl_if.slave  bus
);

    localparam int unsigned CW = min_cnt_w(SNOOZE_MIN, RING_MIN);

    localparam logic [STATE_W-1:0] ST_IDLE    = STATE_W'(IDLE);
    localparam logic [STATE_W-1:0] ST_RINGING = STATE_W'(RINGING);
    localparam logic [STATE_W-1:0] ST_SNOOZED = STATE_W'(SNOOZED);

    if (SNOOZE_MIN < 1 || RING_MIN < 1) begin : g_bad_min
        $error("alarm_time_ctrl: SNOOZE_MIN and RING_MIN must be >= 1");
    end

    logic [MIN_W-1:0] minutes;
    logic [HR_W-1:0]  hours;

    // Minute and hour set-point channels; minute wrap does not carry into hours.
    alarm_adv_ctr #(
        .W       (MIN_W),
        .MOD     (MIN_MOD),
        .REP_DLY (REP_DLY),
        .REP_PER (REP_PER)
    ) u_min (
        .C     (C),
        .CLR_N (CLR_N),
        .EN    (bus.SETUP),
        .BTN   (bus.MIN_ADV),
        .VAL   (minutes)
    );

    alarm_adv_ctr #(
        .W       (HR_W),
        .MOD     (HR_MOD),
        .REP_DLY (REP_DLY),
        .REP_PER (REP_PER)
    ) u_hr (
        .C     (C),
        .CLR_N (CLR_N),
        .EN    (bus.SETUP),
        .BTN   (bus.HR_ADV),
        .VAL   (hours)
    );

    logic [STATE_W-1:0] state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               snz_btn_q, snz_btn_d;
    logic               ring_q, ring_d;
    logic               snoozing_q, snoozing_d;

    logic match_c, snz_rise_c;

    // Alarm engine next state. Disarm/set-mode override beats everything; in RINGING
    // a snooze edge beats a same-cycle timeout. cnt_q holds minutes left in the
    // current RINGING or SNOOZED period.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snz_btn_d  = bus.SNOOZE;
        snz_rise_c = bus.SNOOZE & ~snz_btn_q;
        match_c    = bus.MIN_TICK & (bus.TIME_MIN == minutes) & (bus.TIME_HR == hours);

        if (!bus.ALARM_EN || bus.SETUP) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (match_c) begin
                        state_d = ST_RINGING;
                        cnt_d   = CW'(RING_MIN);
                    end
                end
                ST_RINGING: begin
                    if (snz_rise_c) begin
                        state_d = ST_SNOOZED;
                        cnt_d   = CW'(SNOOZE_MIN);
                    end else if (bus.MIN_TICK) begin
                        if (cnt_q == CW'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (bus.MIN_TICK) begin
                        if (cnt_q == CW'(1)) begin
                            state_d = ST_RINGING;
                            cnt_d   = CW'(RING_MIN);
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        ring_d     = (state_d == ST_RINGING);
        snoozing_d = (state_d == ST_SNOOZED);
    end

    // Engine registers; RING/SNOOZING are flopped decodes of the next state.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            snz_btn_q  <= 1'b0;
            ring_q     <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snz_btn_q  <= snz_btn_d;
            ring_q     <= ring_d;
            snoozing_q <= snoozing_d;
        end
    end

    assign bus.MINUTES  = minutes;
    assign bus.HOURS    = hours;
    assign bus.RING     = ring_q;
    assign bus.SNOOZING = snoozing_q;

endmodule

// File: tb/tb_alarm_time_ctrl.sv
// Directed bench for alarm_time_ctrl with short repeat timing (REP_DLY=10, REP_PER=4).
module tb_alarm_time_ctrl;

    logic C;
    logic CLR_N;
    int   checks   = 0;
    int   failures = 0;

    alarm_time_ctrl_if #(.MIN_W(6), .HR_W(5)) bus ();

    alarm_time_ctrl #(
        .MIN_W      (6),
        .HR_W       (5),
        .MIN_MOD    (60),
        .HR_MOD     (24),
        .REP_DLY    (10),
        .REP_PER    (4),
        .SNOOZE_MIN (9),
        .RING_MIN   (5)
    ) dut (
        .C     (C),
        .CLR_N (CLR_N),
        .bus   (bus)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle past the edge for driving and sampling.
    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic press_min();
        bus.MIN_ADV = 1'b1; step();
        bus.MIN_ADV = 1'b0; step();
    endtask

    task automatic press_hr();
        bus.HR_ADV = 1'b1; step();
        bus.HR_ADV = 1'b0; step();
    endtask

    task automatic press_both();
        bus.MIN_ADV = 1'b1; bus.HR_ADV = 1'b1; step();
        bus.MIN_ADV = 1'b0; bus.HR_ADV = 1'b0; step();
    endtask

    task automatic tick();
        bus.MIN_TICK = 1'b1; step();
        bus.MIN_TICK = 1'b0;
    endtask

    initial begin
        int exp_rep;
        CLR_N        = 1'b0;
        bus.SETUP    = 1'b0;
        bus.MIN_ADV  = 1'b0;
        bus.HR_ADV   = 1'b0;
        bus.ALARM_EN = 1'b0;
        bus.SNOOZE   = 1'b0;
        bus.MIN_TICK = 1'b0;
        bus.TIME_MIN = '0;
        bus.TIME_HR  = '0;
        repeat (3) step();
        chk("rst_min", 32'(bus.MINUTES), 0);
        chk("rst_hr", 32'(bus.HOURS), 0);
        chk("rst_ring", 32'(bus.RING), 0);
        chk("rst_snz", 32'(bus.SNOOZING), 0);
        CLR_N = 1'b1;
        step();
        chk("post_rst_min", 32'(bus.MINUTES), 0);

        // Wrap behaviour
        bus.SETUP = 1'b1;
        repeat (37) press_min();
        chk("min_37", 32'(bus.MINUTES), 37);
        repeat (23) press_min();
        chk("min_wrap", 32'(bus.MINUTES), 0);
        chk("min_wrap_no_carry", 32'(bus.HOURS), 0);
        repeat (23) press_hr();
        chk("hr_23", 32'(bus.HOURS), 23);
        press_hr();
        chk("hr_wrap", 32'(bus.HOURS), 0);
        repeat (59) press_min();
        repeat (23) press_hr();
        chk("min_59", 32'(bus.MINUTES), 59);
        chk("hr_23b", 32'(bus.HOURS), 23);
        press_both();
        chk("both_min_wrap", 32'(bus.MINUTES), 0);
        chk("both_hr_wrap", 32'(bus.HOURS), 0);

        // Auto-repeat: advances after edges 1, 10, 14, 18, 22, 26 of the hold
        bus.MIN_ADV = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (k == 0)      exp_rep = 0;
            else if (k < 10) exp_rep = 1;
            else             exp_rep = 2 + (k - 10) / 4;
            chk($sformatf("rep_k%0d", k), 32'(bus.MINUTES), 32'(exp_rep));
        end
        bus.MIN_ADV = 1'b0;
        repeat (6) step();
        chk("rep_total", 32'(bus.MINUTES), 6);

        // Button ignored outside set mode; held button entering set mode does nothing
        bus.SETUP = 1'b0;
        press_min();
        repeat (3) step();
        chk("no_setup_adv", 32'(bus.MINUTES), 6);
        bus.MIN_ADV = 1'b1;
        step(); step();
        bus.SETUP = 1'b1;
        repeat (20) step();
        chk("held_into_setup", 32'(bus.MINUTES), 6);
        bus.MIN_ADV = 1'b0;
        step();

        // Program alarm 07:30
        repeat (24) press_min();
        repeat (7) press_hr();
        chk("set_min_30", 32'(bus.MINUTES), 30);
        chk("set_hr_7", 32'(bus.HOURS), 7);
        bus.SETUP    = 1'b0;
        bus.ALARM_EN = 1'b1;
        bus.TIME_HR  = 5'd7;
        bus.TIME_MIN = 6'd30;

        // Ring and timeout
        tick();
        bus.TIME_MIN = 6'd0;
        chk("ring_on", 32'(bus.RING), 1);
        chk("ring_on_snz", 32'(bus.SNOOZING), 0);
        repeat (4) tick();
        chk("ring_4_ticks", 32'(bus.RING), 1);
        tick();
        chk("ring_timeout", 32'(bus.RING), 0);
        chk("ring_timeout_snz", 32'(bus.SNOOZING), 0);

        // Snooze and re-ring
        bus.TIME_MIN = 6'd30;
        tick();
        bus.TIME_MIN = 6'd0;
        chk("ring2_on", 32'(bus.RING), 1);
        bus.SNOOZE = 1'b1; step();
        bus.SNOOZE = 1'b0;
        chk("snooze_ring", 32'(bus.RING), 0);
        chk("snooze_flag", 32'(bus.SNOOZING), 1);
        repeat (8) tick();
        chk("snooze_8_ticks", 32'(bus.SNOOZING), 1);
        tick();
        chk("resnooze_ring", 32'(bus.RING), 1);
        chk("resnooze_snz", 32'(bus.SNOOZING), 0);
        repeat (4) tick();
        chk("ring3_4_ticks", 32'(bus.RING), 1);
        bus.SNOOZE   = 1'b1;
        bus.MIN_TICK = 1'b1;
        step();
        bus.SNOOZE   = 1'b0;
        bus.MIN_TICK = 1'b0;
        chk("snooze_beats_timeout", 32'(bus.SNOOZING), 1);
        chk("snooze_beats_timeout_ring", 32'(bus.RING), 0);

        // Overrides
        bus.ALARM_EN = 1'b0; step();
        chk("disarm_snoozed", 32'(bus.SNOOZING), 0);
        chk("disarm_snoozed_ring", 32'(bus.RING), 0);
        bus.ALARM_EN = 1'b1;
        bus.TIME_MIN = 6'd30;
        tick();
        chk("ring4_on", 32'(bus.RING), 1);
        bus.ALARM_EN = 1'b0; step();
        chk("disarm_ringing", 32'(bus.RING), 0);
        bus.ALARM_EN = 1'b1;
        tick();
        chk("ring5_on", 32'(bus.RING), 1);
        bus.SETUP = 1'b1; step();
        chk("setup_ringing", 32'(bus.RING), 0);
        tick();
        chk("match_in_setup", 32'(bus.RING), 0);
        bus.SETUP = 1'b0;
        tick();
        chk("ring6_on", 32'(bus.RING), 1);
        bus.SNOOZE = 1'b1; step();
        bus.SNOOZE = 1'b0;
        chk("snooze2_flag", 32'(bus.SNOOZING), 1);
        bus.SETUP = 1'b1; step();
        chk("setup_snoozed", 32'(bus.SNOOZING), 0);

        // Async reset mid-ring with MINUTES=37
        repeat (7) press_min();
        chk("min_37b", 32'(bus.MINUTES), 37);
        bus.SETUP    = 1'b0;
        bus.TIME_MIN = 6'd37;
        tick();
        chk("ring7_on", 32'(bus.RING), 1);
        #2;
        CLR_N = 1'b0;
        #1;
        chk("async_rst_min", 32'(bus.MINUTES), 0);
        chk("async_rst_hr", 32'(bus.HOURS), 0);
        chk("async_rst_ring", 32'(bus.RING), 0);
        step();
        CLR_N = 1'b1;
        step();
        chk("after_rst_min", 32'(bus.MINUTES), 0);
        chk("after_rst_ring", 32'(bus.RING), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
